cpu_result_monitor: RTL

//  Synthesizable run controller and result checker for mips_cpu. It holds the CPU in reset, releases it on

---
 rtl/cpu_result_monitor.sv | 101 ++++++++++
 1 files changed

// File: rtl/cpu_result_monitor.sv
// Run controller and result checker for mips_cpu: holds the CPU in reset until start, snoops
// data_memory writes into per-channel diagnosis flags, and reports done or timeout until ack.
module cpu_result_monitor #(
    parameter int          NUM_CHANNELS     = 1,
    parameter logic [31:0] RESULT_BASE_ADDR = 32'h0000_000C,
    parameter int          TIMEOUT_CYCLES   = 64,
    parameter int          COUNT_WIDTH      = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    ack,
    input  logic                    mem_we,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    output logic                    cpu_reset,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [NUM_CHANNELS-1:0] result_valid,
    output logic [NUM_CHANNELS-1:0] fever,
    output logic [NUM_CHANNELS-1:0] bad_value,
    output logic [COUNT_WIDTH-1:0]  cycle_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_TIMEOUT} state_t;

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [NUM_CHANNELS-1:0] hit;
    logic [NUM_CHANNELS-1:0] valid_next;
    logic [NUM_CHANNELS-1:0] fever_next;
    logic [NUM_CHANNELS-1:0] bad_next;
    logic                    complete;
    logic                    expired;

    // Completion looks at this cycle's capture too, so the last write ends the run on its own edge.
    always_comb begin
        hit        = '0;
        fever_next = fever;
        bad_next   = bad_value;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            hit[i] = (state == ST_RUN) && mem_we && (mem_addr[1:0] == 2'b00)
                     && (mem_addr == RESULT_BASE_ADDR + 32'(4 * i));
            if (hit[i]) begin
                fever_next[i] = (mem_wdata == 32'd1);
                bad_next[i]   = (mem_wdata > 32'd1);
            end
        end
        valid_next = result_valid | hit;
        complete   = &valid_next;
        expired    = (cycle_count == LAST_COUNT);
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_RUN;
            ST_RUN: begin
                if (complete)     state_next = ST_DONE;
                else if (expired) state_next = ST_TIMEOUT;
            end
            ST_DONE,
            ST_TIMEOUT: if (ack) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Flags freeze outside RUN and survive ack; only an accepted start clears them.
    always_ff @(posedge clock) begin
        if (reset) begin
            result_valid <= '0;
            fever        <= '0;
            bad_value    <= '0;
            cycle_count  <= '0;
        end else if (state == ST_IDLE && start) begin
            result_valid <= '0;
            fever        <= '0;
            bad_value    <= '0;
            cycle_count  <= '0;
        end else if (state == ST_RUN) begin
            result_valid <= valid_next;
            fever        <= fever_next;
            bad_value    <= bad_next;
            if (state_next == ST_RUN) cycle_count <= cycle_count + COUNT_WIDTH'(1);
        end
    end

    assign cpu_reset = (state != ST_RUN);
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign timeout   = (state == ST_TIMEOUT);

endmodule
